freepdk45_sram_fifo_ctrl_32x64: RTL and testbench

Single-clock FIFO controller that sits directly on both ports of the `freepdk45_sram_1w1r_32x64_32` macro. On the write side it packs a stream of 32-bit words into 64-bit SRAM entries using the macro's two write-mask lanes. On the read side it prefetches committed entries through the macro's one-cycle read path into a 2-entry output buffer, so a ready sink sees full throughput. The block feeds the macro's write port and consumes its read port. Together with the macro it forms a 32-entry, 64-bit packing FIFO.

---
 rtl/freepdk45_sram_fifo_ctrl_32x64.sv | 201 ++++++++++++++++++++
 tb/tb_freepdk45_sram_fifo_ctrl_32x64.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freepdk45_sram_fifo_ctrl_32x64.sv
// -----------------------------------------------------------------------------
// freepdk45_sram_fifo_ctrl_32x64
//
// Single-clock packing FIFO controller for the freepdk45_sram_1w1r_32x64_32
// macro. Incoming 32-bit words are packed into 64-bit SRAM entries through the
// macro's two write-mask lanes. Committed entries are prefetched through the
// macro's one-cycle read path into a 2-entry output buffer.
//
// Ports:
//   clk0            single clock (macro clk0 and clk1 are tied to it)
//   rstb0           asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last
//                   32-bit input stream; in_last closes the current entry
//   out_valid/out_ready/out_data/out_keep
//                   64-bit output stream; lower half holds the first word,
//                   out_keep is 01 (lower lane only) or 11
//   fill            committed unread entries + read in flight + buffer entries
//   sram_csb0, sram_wmask0, sram_addr0, sram_din0   macro write port
//   sram_csb1, sram_addr1, sram_dout1               macro read port
// -----------------------------------------------------------------------------
module freepdk45_sram_fifo_ctrl_32x64 #(
    parameter int ADDR_WIDTH = 5,
    parameter int HALF_WIDTH = 32
) (
    input  logic                      clk0,
    input  logic                      rstb0,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [HALF_WIDTH-1:0]     in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*HALF_WIDTH-1:0]   out_data,
    output logic [1:0]                out_keep,
    output logic [ADDR_WIDTH:0]       fill,
    output logic                      sram_csb0,
    output logic [1:0]                sram_wmask0,
    output logic [ADDR_WIDTH-1:0]     sram_addr0,
    output logic [2*HALF_WIDTH-1:0]   sram_din0,
    output logic                      sram_csb1,
    output logic [ADDR_WIDTH-1:0]     sram_addr1,
    input  logic [2*HALF_WIDTH-1:0]   sram_dout1
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int PTR_W   = ADDR_WIDTH + 1;
    localparam int ENTRY_W = 2 * HALF_WIDTH;

    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] FILL_MAX  = PTR_W'(DEPTH + 2);

    // Pointer state: one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic               half_r;
    logic [DEPTH-1:0]   keep_upper_r;
    logic               inflight_r;
    logic               inflight_keep_r;

    // Output buffer: entry 0 is always the head.
    logic [ENTRY_W-1:0] buf0_data_r;
    logic [ENTRY_W-1:0] buf1_data_r;
    logic [1:0]         buf0_keep_r;
    logic [1:0]         buf1_keep_r;
    logic [1:0]         buf_cnt_r;

    logic [PTR_W-1:0]   count_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               commit_s;
    logic               pop_s;
    logic [2:0]         slots_s;
    logic               issue_s;
    logic [PTR_W-1:0]   fill_sum_s;
    logic [1:0]         push_keep_s;

    // Handshake and read-issue decisions from the current state.
    always_comb begin
        count_s    = wr_ptr_r - rd_ptr_r;
        in_ready_s = rstb0 && (count_s != DEPTH_PTR);
        accept_s   = in_valid && in_ready_s;
        commit_s   = accept_s && (half_r || in_last);
        pop_s      = (buf_cnt_r != 2'd0) && out_ready;
        // A buffer slot freed by this cycle's pop can already be claimed by a
        // new read; without that credit a ready sink would see a bubble every
        // third cycle.
        slots_s    = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        // The partial entry at wr_ptr is never counted, so it is never read.
        issue_s    = (count_s != PTR_ZERO) && (slots_s < 3'd2);
        push_keep_s = {inflight_keep_r, 1'b1};
    end

    // Macro write port: the upper or lower lane is enabled by the packing half.
    always_comb begin
        sram_addr0 = wr_ptr_r[ADDR_WIDTH-1:0];
        sram_din0  = {in_data, in_data};
        if (accept_s) begin
            sram_csb0   = 1'b0;
            sram_wmask0 = half_r ? 2'b10 : 2'b01;
        end else begin
            sram_csb0   = 1'b1;
            sram_wmask0 = 2'b00;
        end
    end

    // Macro read port and the visible stream outputs.
    always_comb begin
        sram_addr1 = rd_ptr_r[ADDR_WIDTH-1:0];
        sram_csb1  = ~issue_s;
        in_ready   = in_ready_s;
        out_valid  = (buf_cnt_r != 2'd0);
        out_data   = buf0_data_r;
        out_keep   = buf0_keep_r;
        fill_sum_s = count_s + {{(PTR_W-1){1'b0}}, inflight_r}
                             + {{(PTR_W-2){1'b0}}, buf_cnt_r};
        if (fill_sum_s > FILL_MAX) begin
            fill = FILL_MAX;
        end else begin
            fill = fill_sum_s;
        end
    end

    // Write side: lane packing and entry commit.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            wr_ptr_r     <= PTR_ZERO;
            half_r       <= 1'b0;
            keep_upper_r <= {DEPTH{1'b0}};
        end else if (accept_s) begin
            if (commit_s) begin
                keep_upper_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= half_r;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                half_r   <= 1'b0;
            end else begin
                half_r   <= 1'b1;
            end
        end
    end

    // Read side: the slot is released at issue, so its keep bit travels with
    // the read rather than being looked up again at capture.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            rd_ptr_r        <= PTR_ZERO;
            inflight_r      <= 1'b0;
            inflight_keep_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                rd_ptr_r        <= rd_ptr_r + PTR_ONE;
                inflight_keep_r <= keep_upper_r[rd_ptr_r[ADDR_WIDTH-1:0]];
            end
        end
    end

    // Output buffer: capture read data, shift toward the head on pop.
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            buf0_data_r <= {ENTRY_W{1'b0}};
            buf1_data_r <= {ENTRY_W{1'b0}};
            buf0_keep_r <= 2'b00;
            buf1_keep_r <= 2'b00;
            buf_cnt_r   <= 2'd0;
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (buf_cnt_r == 2'd0) begin
                        buf0_data_r <= sram_dout1;
                        buf0_keep_r <= push_keep_s;
                    end else begin
                        buf1_data_r <= sram_dout1;
                        buf1_keep_r <= push_keep_s;
                    end
                    buf_cnt_r <= buf_cnt_r + 2'd1;
                end
                2'b01: begin
                    buf0_data_r <= buf1_data_r;
                    buf0_keep_r <= buf1_keep_r;
                    buf_cnt_r   <= buf_cnt_r - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_r == 2'd1) begin
                        buf0_data_r <= sram_dout1;
                        buf0_keep_r <= push_keep_s;
                    end else begin
                        buf0_data_r <= buf1_data_r;
                        buf0_keep_r <= buf1_keep_r;
                        buf1_data_r <= sram_dout1;
                        buf1_keep_r <= push_keep_s;
                    end
                end
                default: begin
                    buf_cnt_r <= buf_cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freepdk45_sram_fifo_ctrl_32x64.sv
// -----------------------------------------------------------------------------
// Testbench for freepdk45_sram_fifo_ctrl_32x64. Contains a behavioural model of
// the 1w1r macro (write and read latched at the clock edge) and a packing model
// that pushes expected entries into a scoreboard queue on every accepted word.
// -----------------------------------------------------------------------------
module tb_freepdk45_sram_fifo_ctrl_32x64;

    logic        clk0 = 1'b0;
    logic        rstb0;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_keep;
    logic [5:0]  fill;
    logic        sram_csb0;
    logic [1:0]  sram_wmask0;
    logic [4:0]  sram_addr0;
    logic [63:0] sram_din0;
    logic        sram_csb1;
    logic [4:0]  sram_addr1;
    logic [63:0] sram_dout1 = 64'h0;

    logic [63:0] mem [0:31];

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [$];
    logic [1:0]  keep_q [$];
    logic        half_m;
    logic [31:0] low_m;

    always #5 clk0 = ~clk0;

    freepdk45_sram_fifo_ctrl_32x64 dut (
        .clk0        (clk0),
        .rstb0       (rstb0),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_keep    (out_keep),
        .fill        (fill),
        .sram_csb0   (sram_csb0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_csb1   (sram_csb1),
        .sram_addr1  (sram_addr1),
        .sram_dout1  (sram_dout1)
    );

    // Macro model: masked write and registered read, both taken at the edge.
    always @(posedge clk0) begin
        if (!sram_csb0) begin
            if (sram_wmask0[0]) mem[sram_addr0][31:0]  <= sram_din0[31:0];
            if (sram_wmask0[1]) mem[sram_addr0][63:32] <= sram_din0[63:32];
        end
        if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    end

    // One clock cycle: drive inputs just after posedge, sample at negedge,
    // feed the packing model on accept, return just after the next posedge.
    task automatic cyc(input logic v, input logic [31:0] w, input logic l,
                       input logic r, output logic acc, output logic pop,
                       output logic vld, output logic [63:0] d,
                       output logic [1:0] k);
        in_valid  = v;
        in_data   = w;
        in_last   = l;
        out_ready = r;
        @(negedge clk0);
        acc = in_valid && in_ready;
        vld = out_valid;
        pop = out_valid && out_ready;
        d   = out_data;
        k   = out_keep;
        if (acc) begin
            if (!half_m) begin
                low_m = w;
                if (l) begin
                    exp_q.push_back({32'h0, w});
                    keep_q.push_back(2'b01);
                end else begin
                    half_m = 1'b1;
                end
            end else begin
                exp_q.push_back({w, low_m});
                keep_q.push_back(2'b11);
                half_m = 1'b0;
            end
        end
        @(posedge clk0);
        #1;
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rstb0     = 1'b0;
        exp_q.delete();
        keep_q.delete();
        half_m = 1'b0;
        repeat (2) @(posedge clk0);
        #1;
        rstb0 = 1'b1;
        @(posedge clk0);
        #1;
    endtask

    task automatic test_reset();
        rstb0     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hFFFF_FFFF;
        in_last   = 1'b1;
        out_ready = 1'b1;
        half_m    = 1'b0;
        repeat (3) @(posedge clk0);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || fill !== 6'd0) begin
            failures++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b fill=%0d, required 0 0 0", in_ready, out_valid, fill);
        end
        checks++;
        if (out_data !== 64'h0 || out_keep !== 2'b00) begin
            failures++;
            $display("FAIL reset_out: data=%h keep=%b, required 0 and 00", out_data, out_keep);
        end
        checks++;
        if (sram_csb0 !== 1'b1 || sram_wmask0 !== 2'b00 || sram_addr0 !== 5'd0) begin
            failures++;
            $display("FAIL reset_wport: csb0=%b wmask0=%b addr0=%0d, required 1 00 0", sram_csb0, sram_wmask0, sram_addr0);
        end
        checks++;
        if (sram_csb1 !== 1'b1 || sram_addr1 !== 5'd0) begin
            failures++;
            $display("FAIL reset_rport: csb1=%b addr1=%0d, required 1 0", sram_csb1, sram_addr1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rstb0     = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk0);
        #1;
    endtask

    // Scenario: pops every remaining scoreboard entry in order, bounded.
    task automatic test_drain(input string name);
        logic acc, pop, vld;
        logic [63:0] d, ed;
        logic [1:0]  k, ek;
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1, acc, pop, vld, d, k);
            if (pop) begin
                ed = exp_q.pop_front();
                ek = keep_q.pop_front();
                checks++;
                if (k !== ek || d[31:0] !== ed[31:0] || (ek == 2'b11 && d[63:32] !== ed[63:32])) begin
                    failures++;
                    $display("FAIL %s_data: got keep=%b data=%h, required keep=%b data=%h", name, k, d, ek, ed);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d entries never delivered, required 0", name, exp_q.size());
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_extra: out_valid=%b after last entry, required 0", name, out_valid);
        end
    endtask

    task automatic test_pair();
        logic acc, pop, vld;
        logic [63:0] d;
        logic [1:0]  k;
        in_valid = 1'b1; in_data = 32'h1111_1111; in_last = 1'b0; out_ready = 1'b0;
        #1;
        checks++;
        if (sram_csb0 !== 1'b0 || sram_wmask0 !== 2'b01 || sram_addr0 !== 5'd0 || sram_din0 !== 64'h1111_1111_1111_1111) begin
            failures++;
            $display("FAIL pair_wr0: csb0=%b wmask0=%b addr0=%0d din0=%h, required 0 01 0 1111111111111111", sram_csb0, sram_wmask0, sram_addr0, sram_din0);
        end
        cyc(1'b1, 32'h1111_1111, 1'b0, 1'b0, acc, pop, vld, d, k);
        in_data = 32'h2222_2222;
        #1;
        checks++;
        if (sram_csb0 !== 1'b0 || sram_wmask0 !== 2'b10 || sram_addr0 !== 5'd0) begin
            failures++;
            $display("FAIL pair_wr1: csb0=%b wmask0=%b addr0=%0d, required 0 10 0", sram_csb0, sram_wmask0, sram_addr0);
        end
        cyc(1'b1, 32'h2222_2222, 1'b0, 1'b0, acc, pop, vld, d, k);
        // Just after the commit edge: read issues for slot 0.
        in_valid = 1'b0;
        #1;
        checks++;
        if (sram_csb1 !== 1'b0 || sram_addr1 !== 5'd0 || fill !== 6'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pair_issue: csb1=%b addr1=%0d fill=%0d out_valid=%b, required 0 0 1 0", sram_csb1, sram_addr1, fill, out_valid);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, acc, pop, vld, d, k);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pair_early: out_valid=%b one edge after commit, required 0", out_valid);
        end
        cyc(1'b0, 32'h0, 1'b0, 1'b0, acc, pop, vld, d, k);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h2222_2222_1111_1111 || out_keep !== 2'b11) begin
            failures++;
            $display("FAIL pair_latency: out_valid=%b data=%h keep=%b, required 1 2222222211111111 11", out_valid, out_data, out_keep);
        end
        test_drain("pair");
    endtask

    task automatic test_single_last();
        logic acc, pop, vld;
        logic [63:0] d;
        logic [1:0]  k;
        apply_reset();
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
        #1;
        checks++;
        if (sram_wmask0 !== 2'b01 || sram_addr0 !== 5'd0) begin
            failures++;
            $display("FAIL last_wr: wmask0=%b addr0=%0d, required 01 0", sram_wmask0, sram_addr0);
        end
        cyc(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, acc, pop, vld, d, k);
        in_data = 32'h3333_3333; in_last = 1'b0;
        #1;
        checks++;
        if (sram_wmask0 !== 2'b01 || sram_addr0 !== 5'd1) begin
            failures++;
            $display("FAIL last_next: wmask0=%b addr0=%0d, required 01 1", sram_wmask0, sram_addr0);
        end
        cyc(1'b1, 32'h3333_3333, 1'b0, 1'b0, acc, pop, vld, d, k);
        cyc(1'b1, 32'h4444_4444, 1'b0, 1'b0, acc, pop, vld, d, k);
        test_drain("last");
    endtask

    task automatic test_full();
        logic acc, pop, vld;
        logic [63:0] d, ed;
        logic [1:0]  k, ek;
        int nacc = 0, ncyc = 0, npop = 0, first = -1, lastc = -1;
        while (nacc < 68 && ncyc < 200) begin
            cyc(1'b1, 32'hA000_0000 + nacc, 1'b0, 1'b0, acc, pop, vld, d, k);
            if (acc) nacc++;
            ncyc++;
        end
        checks++;
        if (ncyc != 68) begin
            failures++;
            $display("FAIL full_accept: %0d cycles for 68 words, required 68", ncyc);
        end
        checks++;
        if (in_ready !== 1'b0 || fill !== 6'd34) begin
            failures++;
            $display("FAIL full_state: in_ready=%b fill=%0d, required 0 34", in_ready, fill);
        end
        for (int n = 0; n < 2; n++) begin
            cyc(1'b1, 32'hBAD0_0000, 1'b0, 1'b0, acc, pop, vld, d, k);
            checks++;
            if (acc !== 1'b0) begin
                failures++;
                $display("FAIL full_block: word accepted while full, required no accept");
            end
        end
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b1, acc, pop, vld, d, k);
            if (pop) begin
                if (first < 0) first = n;
                lastc = n;
                npop++;
                ed = exp_q.pop_front();
                ek = keep_q.pop_front();
                checks++;
                if (k !== ek || d !== ed) begin
                    failures++;
                    $display("FAIL full_data: got keep=%b data=%h, required keep=%b data=%h", k, d, ek, ed);
                end
            end
        end
        checks++;
        if (npop != 34 || (lastc - first + 1) != 34) begin
            failures++;
            $display("FAIL full_drain: %0d entries over %0d cycles, required 34 over 34", npop, lastc - first + 1);
        end
        test_drain("full");
    endtask

    task automatic test_stream();
        logic acc, pop, vld;
        logic [63:0] d, ed;
        logic [1:0]  k, ek;
        int nacc = 0, ncyc = 0;
        while (nacc < 200 && ncyc < 400) begin
            cyc(1'b1, 32'h5000_0000 + nacc * 7, (nacc % 29) == 28, 1'b1, acc, pop, vld, d, k);
            if (acc) nacc++;
            ncyc++;
            if (pop) begin
                ed = exp_q.pop_front();
                ek = keep_q.pop_front();
                checks++;
                if (k !== ek || d[31:0] !== ed[31:0] || (ek == 2'b11 && d[63:32] !== ed[63:32])) begin
                    failures++;
                    $display("FAIL stream_data: got keep=%b data=%h, required keep=%b data=%h", k, d, ek, ed);
                end
            end
        end
        checks++;
        if (ncyc != 200) begin
            failures++;
            $display("FAIL stream_rate: %0d cycles for 200 words, required 200", ncyc);
        end
        test_drain("stream");
    endtask

    task automatic test_random_ready();
        logic acc, pop, vld;
        logic [63:0] d, ed, prev_d;
        logic [1:0]  k, ek, prev_k;
        logic prev_stall = 1'b0;
        int nacc = 0;
        for (int n = 0; n < 600 && nacc < 150; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, acc, pop, vld, d, k);
            if (acc) nacc++;
            if (prev_stall) begin
                checks++;
                if (!vld || d !== prev_d || k !== prev_k) begin
                    failures++;
                    $display("FAIL rand_stable: valid=%b data=%h keep=%b, required 1 %h %b", vld, d, k, prev_d, prev_k);
                end
            end
            prev_stall = vld && !pop;
            prev_d = d;
            prev_k = k;
            if (pop) begin
                ed = exp_q.pop_front();
                ek = keep_q.pop_front();
                checks++;
                if (k !== ek || d[31:0] !== ed[31:0] || (ek == 2'b11 && d[63:32] !== ed[63:32])) begin
                    failures++;
                    $display("FAIL rand_data: got keep=%b data=%h, required keep=%b data=%h", k, d, ek, ed);
                end
            end
        end
        if (half_m) cyc(1'b1, 32'h7777_7777, 1'b1, 1'b0, acc, pop, vld, d, k);
        test_drain("rand");
    endtask

    task automatic test_reset_mid();
        logic acc, pop, vld;
        logic [63:0] d;
        logic [1:0]  k;
        for (int n = 0; n < 11; n++) cyc(1'b1, 32'hC000_0000 + n, 1'b0, 1'b0, acc, pop, vld, d, k);
        rstb0 = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'h0 || out_keep !== 2'b00 || fill !== 6'd0) begin
            failures++;
            $display("FAIL mid_out: in_ready=%b out_valid=%b data=%h keep=%b fill=%0d, required all 0", in_ready, out_valid, out_data, out_keep, fill);
        end
        checks++;
        if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || sram_wmask0 !== 2'b00 || sram_addr0 !== 5'd0 || sram_addr1 !== 5'd0) begin
            failures++;
            $display("FAIL mid_sram: csb0=%b csb1=%b wmask0=%b addr0=%0d addr1=%0d, required 1 1 00 0 0", sram_csb0, sram_csb1, sram_wmask0, sram_addr0, sram_addr1);
        end
        exp_q.delete();
        keep_q.delete();
        half_m = 1'b0;
        repeat (2) @(posedge clk0);
        #1;
        rstb0 = 1'b1;
        in_data = 32'h5555_5555; in_last = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || sram_csb0 !== 1'b0 || sram_addr0 !== 5'd0 || sram_wmask0 !== 2'b01) begin
            failures++;
            $display("FAIL mid_restart: in_ready=%b csb0=%b addr0=%0d wmask0=%b, required 1 0 0 01", in_ready, sram_csb0, sram_addr0, sram_wmask0);
        end
        cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0, acc, pop, vld, d, k);
        cyc(1'b1, 32'h6666_6666, 1'b0, 1'b0, acc, pop, vld, d, k);
        test_drain("mid");
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'h0;
        in_data = 32'h0;
        low_m   = 32'h0;
        test_reset();
        test_pair();
        test_single_last();
        test_full();
        test_stream();
        test_random_ready();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
